// File: rtl/lm80c_ps2_keymatrix_if.sv
// Bundle of the PS/2 line inputs and keyboard-matrix outputs of lm80c_ps2_keymatrix.
// master: the keyboard front end (samples PS/2 lines, drives matrix/status).
// slave:  the surroundings (drive PS/2 lines, read matrix/status).
`timescale 1ns/1ps
interface lm80c_ps2_keymatrix_if;
    logic            ps2_clk;
    logic            ps2_data;
    logic [7:0][7:0] KM;
    logic            reset_key;
    logic            key_strobe;
    logic [7:0]      key_code;
    logic            frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output KM, reset_key, key_strobe, key_code, frame_err
    );
    modport slave (
        output ps2_clk, ps2_data,
        input  KM, reset_key, key_strobe, key_code, frame_err
    );
endinterface

// File: rtl/lm80c_ps2_keymatrix.sv
// PS/2 set-2 receiver feeding the LM80C 8x8 active-low keyboard matrix.
// Raw lines are synchronised and debounced, frames are decoded by a small FSM,
// E0/F0 prefixes are tracked and each key event updates one matrix cell.
// F12 raises reset_key while held.
`timescale 1ns/1ps
module lm80c_ps2_keymatrix #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         sys_clock,
    input  logic                         reset_n,
    lm80c_ps2_keymatrix_if.master        kbd
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic [FW-1:0]   clk_cnt_q, dat_cnt_q;
    logic            clk_filt_q, dat_filt_q, clk_prev_q, fall_q;
    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TW-1:0]   to_cnt_q;
    logic            timeout_s, byte_ok_s, err_s;
    logic            key_strobe_q, frame_err_q, reset_key_q, ext_q, brk_q;
    logic [7:0]      key_code_q;
    logic [7:0][7:0] km_q;
    logic [6:0]      map_s;

    // {ext,code} -> {hit,row,col}; one case item per key of the LM80C layout
    function automatic logic [6:0] km_map(input logic [8:0] code);
        logic [6:0] m;
        m = 7'd0;
        case (code)
            9'h012: m = {1'b1, 3'd0, 3'd0};  9'h059: m = {1'b1, 3'd0, 3'd0};  // LSHIFT, RSHIFT
            9'h005: m = {1'b1, 3'd0, 3'd1};  9'h006: m = {1'b1, 3'd0, 3'd2};  // F1, F2
            9'h004: m = {1'b1, 3'd0, 3'd3};  9'h00C: m = {1'b1, 3'd0, 3'd4};  // F3, F4
            9'h003: m = {1'b1, 3'd0, 3'd5};  9'h05A: m = {1'b1, 3'd0, 3'd6};  // F5, ENTER
            9'h15A: m = {1'b1, 3'd0, 3'd6};  9'h066: m = {1'b1, 3'd0, 3'd7};  // KP ENTER, BKSP
            9'h016: m = {1'b1, 3'd1, 3'd0};  9'h01E: m = {1'b1, 3'd1, 3'd1};  // 1, 2
            9'h026: m = {1'b1, 3'd1, 3'd2};  9'h025: m = {1'b1, 3'd1, 3'd3};  // 3, 4
            9'h02E: m = {1'b1, 3'd1, 3'd4};  9'h036: m = {1'b1, 3'd1, 3'd5};  // 5, 6
            9'h03D: m = {1'b1, 3'd1, 3'd6};  9'h03E: m = {1'b1, 3'd1, 3'd7};  // 7, 8
            9'h015: m = {1'b1, 3'd2, 3'd0};  9'h01C: m = {1'b1, 3'd2, 3'd1};  // Q, A
            9'h01D: m = {1'b1, 3'd2, 3'd2};  9'h01B: m = {1'b1, 3'd2, 3'd3};  // W, S
            9'h024: m = {1'b1, 3'd2, 3'd4};  9'h023: m = {1'b1, 3'd2, 3'd5};  // E, D
            9'h02D: m = {1'b1, 3'd2, 3'd6};  9'h02B: m = {1'b1, 3'd2, 3'd7};  // R, F
            9'h02C: m = {1'b1, 3'd3, 3'd0};  9'h034: m = {1'b1, 3'd3, 3'd1};  // T, G
            9'h035: m = {1'b1, 3'd3, 3'd2};  9'h033: m = {1'b1, 3'd3, 3'd3};  // Y, H
            9'h03C: m = {1'b1, 3'd3, 3'd4};  9'h03B: m = {1'b1, 3'd3, 3'd5};  // U, J
            9'h043: m = {1'b1, 3'd3, 3'd6};  9'h042: m = {1'b1, 3'd3, 3'd7};  // I, K
            9'h044: m = {1'b1, 3'd4, 3'd0};  9'h04B: m = {1'b1, 3'd4, 3'd1};  // O, L
            9'h04D: m = {1'b1, 3'd4, 3'd2};  9'h01A: m = {1'b1, 3'd4, 3'd3};  // P, Z
            9'h022: m = {1'b1, 3'd4, 3'd4};  9'h021: m = {1'b1, 3'd4, 3'd5};  // X, C
            9'h02A: m = {1'b1, 3'd4, 3'd6};  9'h032: m = {1'b1, 3'd4, 3'd7};  // V, B
            9'h031: m = {1'b1, 3'd5, 3'd0};  9'h03A: m = {1'b1, 3'd5, 3'd1};  // N, M
            9'h041: m = {1'b1, 3'd5, 3'd2};  9'h049: m = {1'b1, 3'd5, 3'd3};  // comma, period
            9'h04A: m = {1'b1, 3'd5, 3'd4};  9'h046: m = {1'b1, 3'd5, 3'd5};  // slash, 9
            9'h045: m = {1'b1, 3'd5, 3'd6};  9'h04E: m = {1'b1, 3'd5, 3'd7};  // 0, minus
            9'h055: m = {1'b1, 3'd6, 3'd0};  9'h04C: m = {1'b1, 3'd6, 3'd1};  // equals, semicolon
            9'h052: m = {1'b1, 3'd6, 3'd2};  9'h054: m = {1'b1, 3'd6, 3'd3};  // quote, [
            9'h05B: m = {1'b1, 3'd6, 3'd4};  9'h00D: m = {1'b1, 3'd6, 3'd5};  // ], TAB
            9'h076: m = {1'b1, 3'd6, 3'd6};  9'h014: m = {1'b1, 3'd6, 3'd7};  // ESC, LCTRL
            9'h114: m = {1'b1, 3'd6, 3'd7};  9'h011: m = {1'b1, 3'd7, 3'd0};  // RCTRL, LALT
            9'h111: m = {1'b1, 3'd7, 3'd0};  9'h16B: m = {1'b1, 3'd7, 3'd1};  // RALT, LEFT
            9'h174: m = {1'b1, 3'd7, 3'd2};  9'h175: m = {1'b1, 3'd7, 3'd3};  // RIGHT, UP
            9'h029: m = {1'b1, 3'd7, 3'd4};  9'h172: m = {1'b1, 3'd7, 3'd5};  // SPACE, DOWN
            9'h16C: m = {1'b1, 3'd7, 3'd6};  9'h058: m = {1'b1, 3'd7, 3'd7};  // HOME, CAPS
            default: m = 7'd0;
        endcase
        return m;
    endfunction

    // Two-flop synchronizers and saturating-count glitch filters for both PS/2 lines
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;   dat_sync_q <= 2'b11;
            clk_cnt_q  <= '0;      dat_cnt_q  <= '0;
            clk_filt_q <= 1'b1;    dat_filt_q <= 1'b1;
            clk_prev_q <= 1'b1;    fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], kbd.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], kbd.ps2_data};
            if (clk_sync_q[1] == clk_filt_q) begin
                clk_cnt_q <= '0;
            end else if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
                clk_filt_q <= clk_sync_q[1];
                clk_cnt_q  <= '0;
            end else begin
                clk_cnt_q <= clk_cnt_q + FW'(1);
            end
            if (dat_sync_q[1] == dat_filt_q) begin
                dat_cnt_q <= '0;
            end else if (dat_cnt_q == FW'(FILTER_LEN - 1)) begin
                dat_filt_q <= dat_sync_q[1];
                dat_cnt_q  <= '0;
            end else begin
                dat_cnt_q <= dat_cnt_q + FW'(1);
            end
            clk_prev_q <= clk_filt_q;
            fall_q     <= clk_prev_q & ~clk_filt_q;
        end
    end

    // Abort an open frame when the clock stops falling for TIMEOUT_CYCLES
    assign timeout_s = (state_q != ST_IDLE) && !fall_q && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Receive FSM state register
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Receive FSM next state: advance one step per filtered clock fall
    always_comb begin
        state_d = state_q;
        if (timeout_s) begin
            state_d = ST_IDLE;
        end else if (fall_q) begin
            case (state_q)
                ST_IDLE:   state_d = dat_filt_q ? ST_IDLE : ST_DATA;
                ST_DATA:   state_d = (bit_cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receive FSM outputs: byte accepted on a good stop bit, error on bad start/parity/stop or timeout
    always_comb begin
        byte_ok_s = 1'b0;
        err_s     = timeout_s;
        if (fall_q) begin
            case (state_q)
                ST_IDLE: err_s = dat_filt_q;
                ST_STOP: begin
                    byte_ok_s = dat_filt_q & (^{par_q, shift_q});
                    err_s     = ~(dat_filt_q & (^{par_q, shift_q}));
                end
                default: err_s = 1'b0;
            endcase
        end else begin
            byte_ok_s = 1'b0;
        end
    end

    // Frame datapath: bit counter, LSB-first shift register, parity bit, inactivity counter
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            if (fall_q) begin
                case (state_q)
                    ST_IDLE:   bit_cnt_q <= 3'd0;
                    ST_DATA: begin
                        shift_q   <= {dat_filt_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    ST_PARITY: par_q <= dat_filt_q;
                    default:   ;
                endcase
            end
            if (fall_q || state_q == ST_IDLE) to_cnt_q <= '0;
            else if (!timeout_s)              to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    // Registered byte strobe, last byte and error pulse
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            key_strobe_q <= 1'b0;
            key_code_q   <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            key_strobe_q <= byte_ok_s;
            frame_err_q  <= err_s;
            if (byte_ok_s) key_code_q <= shift_q;
        end
    end

    // Matrix lookup of the byte currently being decoded
    always_comb begin
        map_s = km_map({ext_q, key_code_q});
    end

    // Decode accepted bytes into prefix flags, one matrix cell and the F12 reset request
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            km_q        <= {8{8'hFF}};
            reset_key_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else if (timeout_s) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (key_strobe_q) begin
            case (key_code_q)
                8'hE0:        ext_q <= 1'b1;
                8'hF0:        brk_q <= 1'b1;
                8'hE1, 8'hAA: ;
                default: begin
                    if (map_s[6]) km_q[map_s[5:3]][map_s[2:0]] <= brk_q;
                    if (!ext_q && key_code_q == 8'h07) reset_key_q <= ~brk_q;
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            endcase
        end
    end

    assign kbd.KM         = km_q;
    assign kbd.reset_key  = reset_key_q;
    assign kbd.key_strobe = key_strobe_q;
    assign kbd.key_code   = key_code_q;
    assign kbd.frame_err  = frame_err_q;
endmodule
